// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM state type and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MERGE = 2'b10
  } state_t;

  // Halves need an even address, words a word-aligned one; size 11 never aligns.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed little-endian lane of a RAM word and zero- or
// sign-extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_offset, 3'b000} +: 8];
    w_half   = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_result = i_word;
    case (i_size)
      SZ_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: word stores in one cycle, loads and
// sub-word stores (read-modify-write) in two cycles over one RAM port.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [1:0]            dbg_state
);

  // Handshake: a request (req_valid) is taken only in IDLE. When the accepting
  // cycle raises stall, the requester holds req_* until the next cycle, where
  // stall is low and the request is already consumed and must be advanced.

  state_t                r_state, w_next_state;
  logic [1:0]            r_offset, r_size;
  logic                  r_signed;
  logic [15:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data, w_ram_data;
  logic                  w_latch;
  logic                  w_mis;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [31:0]           w_load;

  assign w_mis     = is_misaligned(req_size, req_addr[1:0]);
  assign ram_addr  = w_ram_addr;
  assign ram_data  = w_ram_data;
  assign dbg_state = r_state;
  assign rsp_rdata = rsp_valid ? w_load : '0;

  dmem_load_align u_align (
    .i_word   (ram_q),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_result (w_load)
  );

  always_comb begin
    w_merged = ram_q;
    case (r_size)
      SZ_BYTE: w_merged[{r_offset, 3'b000} +: 8] = r_wdata[7:0];
      SZ_HALF: begin
        if (r_offset[1]) w_merged[31:16] = r_wdata;
        else             w_merged[15:0]  = r_wdata;
      end
      default: w_merged = ram_q;
    endcase
  end

  // ram_addr/ram_data hold their last driven value; MERGE relies on this to
  // write back to the address read in the accepting cycle.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    rsp_valid    = 1'b0;
    misalign     = 1'b0;
    ram_we       = 1'b0;
    w_latch      = 1'b0;
    w_ram_addr   = r_ram_addr;
    w_ram_data   = r_ram_data;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_mis) begin
              misalign = 1'b1;
            end else if (req_we && req_size == SZ_WORD) begin
              ram_we     = 1'b1;
              w_ram_addr = req_addr[ADDR_WIDTH+1:2];
              w_ram_data = req_wdata;
            end else begin
              w_ram_addr   = req_addr[ADDR_WIDTH+1:2];
              stall        = 1'b1;
              w_latch      = 1'b1;
              w_next_state = req_we ? ST_MERGE : ST_READ;
            end
          end
        end
        ST_READ: begin
          rsp_valid    = 1'b1;
          w_next_state = ST_IDLE;
        end
        ST_MERGE: begin
          ram_we       = 1'b1;
          w_ram_data   = w_merged;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_offset   <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_wdata    <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_state    <= w_next_state;
      r_ram_addr <= w_ram_addr;
      r_ram_data <= w_ram_data;
      if (w_latch) begin
        r_offset <= req_addr[1:0];
        r_size   <= req_size;
        r_signed <= req_signed;
        r_wdata  <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data-memory word width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: data-memory word-address width.
REQ-003 SHALL have port clk, in, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, in, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, in, 1: a MEM-stage access is presented.
REQ-006 SHALL have port req_we, in, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, in, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed, in, 1: sign-extend a sub-word load.
REQ-009 SHALL have port req_addr, in, ADDR_WIDTH+2: byte address.
REQ-010 SHALL have port req_wdata, in, 32: store data, right-aligned.
REQ-011 SHALL have port stall, out, 1: pipeline hold request.
REQ-012 SHALL have port rsp_valid, out, 1: rsp_rdata is valid this cycle.
REQ-013 SHALL have port rsp_rdata, out, 32: load result, aligned and extended.
REQ-014 SHALL have port misalign, out, 1: one-cycle address/size exception pulse.
REQ-015 SHALL have ports ram_addr (out, ADDR_WIDTH), ram_data (out, 32), ram_we (out, 1) and ram_q (in, 32): one port of the synchronous data RAM, with one cycle of read latency and write-first behaviour.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ and MERGE; requests are accepted only in IDLE, and req_* is ignored in READ and MERGE.
REQ-017 SHALL use little-endian byte lanes: byte offset addr[1:0]=k maps to bits 8k+7:8k, and a half at offset 0 or 2 maps to bits 15:0 or 31:16.
REQ-018 SHALL treat an access as misaligned if: half with addr[0]=1, or word with addr[1:0]!=0, or size 11. For a misaligned access in IDLE, misalign=1 for that cycle; there is no RAM write, no rsp_valid, stall=0, and the FSM stays in IDLE.
REQ-019 SHALL handle a word store in IDLE in one cycle: ram_addr=addr[ADDR_WIDTH+1:2], ram_data=req_wdata, ram_we=1, stall=0, FSM stays in IDLE.
REQ-020 SHALL handle a load in IDLE as follows. Cycle 0: drive ram_addr with ram_we=0 and stall=1, latch offset/size/signed, go to READ. Cycle 1 (READ): rsp_valid=1, rsp_rdata = selected lane of ram_q, zero- or sign-extended per the latched signed flag, stall=0, go to IDLE.
REQ-021 SHALL handle a sub-word store in IDLE as follows. Cycle 0: read the word with stall=1, latch addr/size/wdata, go to MERGE. Cycle 1 (MERGE): ram_data = ram_q with only the addressed lane(s) replaced by the low byte/half of the latched wdata, ram_we=1 to the same ram_addr, stall=0, go to IDLE.
REQ-022 SHALL keep stall high only in the accepting cycle; the requester holds req_* stable while stall=1, and at most one access completes per two cycles for multi-cycle operations.
REQ-023 SHALL drive ram_we=0, rsp_valid=0, misalign=0 and stall=0 in IDLE with req_valid=0; ram_addr and ram_data are don't-care whenever ram_we=0, but SHALL be deterministic (hold last value).
REQ-024 SHALL drive rsp_rdata to 0 whenever rsp_valid=0.

Reset
REQ-025 SHALL, while rst=1, force FSM=IDLE, clear the latched registers, and drive stall, rsp_valid, misalign and ram_we to 0 regardless of req_*.
REQ-026 SHALL abandon an operation in progress when rst is asserted in READ or MERGE: no RAM write is issued and no response is produced.

Structure
REQ-027 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type in shared package dmem_pkg.
REQ-028 SHALL implement the lane select and extension in sub-module dmem_load_align (inputs word, offset, size, signed; output 32-bit result), instantiated once.

Verification
REQ-029 SHALL verify word store then load: store 0xDEADBEEF at byte addr 0x08, then load word at 0x08 -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF, stall high for exactly 1 cycle.
REQ-030 SHALL verify signed byte load: with word 0x80FF7F01 at 0x04, lb 0x07 -> 0xFFFFFF80; lbu 0x07 -> 0x00000080; lb 0x04 -> 0x00000001.
REQ-031 SHALL verify sub-word store merge: with word 0x11223344 at 0x0C, sh 0xABCD to 0x0E -> ram_we one cycle after accept with ram_data=0xABCD3344; sb 0x55 to 0x0D -> 0xABCD5544.
REQ-032 SHALL verify misalignment: lw 0x02, sh 0x01 and size=11 each -> misalign pulse of 1 cycle, ram_we never 1, rsp_valid never 1.
REQ-033 SHALL verify reset mid-operation: rst asserted in the MERGE cycle of sb 0x77 to 0x10 -> ram_we stays 0, the word at 0x10 is unchanged on readback, and the FSM is in IDLE after rst.
REQ-034 SHALL verify back-to-back accesses: sb then lw presented with stall honoured -> lw returns the merged value (write-first ordering).
